// File: rtl/sprite_spawn.sv
// Per-sprite motion generator: on a start request, sweeps the horizontal and
// vertical offsets linearly from SRC to DST over STEP ticks, then parks at DST.
`timescale 1ns/1ps

module sprite_spawn_axis #(
  parameter int                    W    = 12,
  parameter int                    LOG2 = 5,
  parameter logic signed [W-1:0]   SRC  = '0,
  parameter logic signed [W-1:0]   DST  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] offset
);

  // Two guard bits above W+LOG2 keep delta*k free of overflow for any k <= STEP.
  localparam int PW = W + LOG2 + 2;
  localparam logic signed [PW-1:0] SRC_X = {{(PW-W){SRC[W-1]}}, SRC};
  localparam logic signed [PW-1:0] DST_X = {{(PW-W){DST[W-1]}}, DST};
  localparam logic signed [PW-1:0] DELTA = DST_X - SRC_X;

  // acc_reg holds delta*k, built up one delta per tick instead of multiplying.
  logic signed [PW-1:0] acc_reg, acc_next;
  logic signed [PW-1:0] acc_step;
  logic signed [PW-1:0] scaled;
  logic        [W-1:0]  offset_reg, offset_next;

  always_comb begin
    acc_next    = acc_reg;
    offset_next = offset_reg;
    acc_step    = acc_reg + DELTA;
    scaled      = SRC_X + (acc_step >>> LOG2);
    if (load) begin
      acc_next    = '0;
      offset_next = SRC;
    end else if (advance) begin
      acc_next    = acc_step;
      offset_next = scaled[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      offset_reg <= DST;
    end else begin
      acc_reg    <= acc_next;
      offset_reg <= offset_next;
    end
  end

  assign offset = offset_reg;

endmodule

module sprite_spawn #(
  parameter int                         HWIDTH = 12,
  parameter int                         VWIDTH = 12,
  parameter logic signed [HWIDTH-1:0]   HSRC   = '0,
  parameter logic signed [VWIDTH-1:0]   VSRC   = '0,
  parameter logic signed [HWIDTH-1:0]   HDST   = '0,
  parameter logic signed [VWIDTH-1:0]   VDST   = '0,
  parameter int                         STEP   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [HWIDTH-1:0] hoffset,
  output logic [VWIDTH-1:0] voffset,
  output logic              active
);

  localparam int LOG2 = $clog2(STEP);
  localparam int KW   = LOG2 + 1;

  generate
    if (STEP < 2 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
      $error("sprite_spawn: STEP must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic            load;
  logic            advance;

  // The final tick (k == STEP) keeps active high and holds DST; the next edge parks.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (en) begin
          state_next = S_RUN;
          k_next     = '0;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        if (k_reg == KW'(STEP)) begin
          state_next = S_IDLE;
          k_next     = '0;
        end else begin
          k_next  = k_reg + KW'(1);
          advance = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        k_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  assign active = (state_reg == S_RUN);

  sprite_spawn_axis #(
    .W(HWIDTH), .LOG2(LOG2), .SRC(HSRC), .DST(HDST)
  ) u_haxis (
    .clk(clk), .rst_n(rst_n), .load(load), .advance(advance), .offset(hoffset)
  );

  sprite_spawn_axis #(
    .W(VWIDTH), .LOG2(LOG2), .SRC(VSRC), .DST(VDST)
  ) u_vaxis (
    .clk(clk), .rst_n(rst_n), .load(load), .advance(advance), .offset(voffset)
  );

endmodule

// File: tb/tb_sprite_spawn.sv
// Scoreboard bench for sprite_spawn: a sweep/interpolation reference model
// queues expected outputs per tick, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_sprite_spawn;

  localparam int STEP = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [11:0] h, v, h2, v2;
  logic        act, act2;

  always #5 clk = ~clk;

  sprite_spawn #(
    .HWIDTH(12), .VWIDTH(12), .HSRC(-80), .VSRC(-140),
    .HDST(-120), .VDST(220), .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hoffset(h), .voffset(v), .active(act)
  );

  sprite_spawn #(
    .HWIDTH(12), .VWIDTH(12), .HSRC(0), .VSRC(-300),
    .HDST(0), .VDST(400), .STEP(STEP)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hoffset(h2), .voffset(v2), .active(act2)
  );

  typedef struct {
    logic        act;
    logic [11:0] h, v, h2, v2;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  int   m_act = 0;
  int   m_k = 0;

  // Linear interpolation with the quotient rounded toward negative infinity.
  function automatic logic [11:0] lerp(int src, int dst, int k);
    int n, q;
    n = (dst - src) * k;
    q = n / STEP;
    if (n < 0 && q * STEP != n) q = q - 1;
    return 12'(src + q);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.act = (m_act != 0);
    e.h   = m_act != 0 ? lerp(-80, -120, m_k)  : 12'hF88;
    e.v   = m_act != 0 ? lerp(-140, 220, m_k)  : 12'h0DC;
    e.h2  = m_act != 0 ? lerp(0, 0, m_k)       : 12'h000;
    e.v2  = m_act != 0 ? lerp(-300, 400, m_k)  : 12'h190;
    return e;
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One clock tick: apply en, advance the model for this edge, queue the expectation.
  task automatic tick(input logic e);
    en = e;
    if (!rst_n) begin
      m_act = 0; m_k = 0;
    end else if (m_act != 0) begin
      if (m_k == STEP) begin
        m_act = 0; m_k = 0;
      end else begin
        m_k++;
      end
    end else if (e) begin
      m_act = 1; m_k = 0;
    end
    sb.push_back(expect_now());
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_active",  {11'b0, act},  12'h000);
    chk("rst_hoffset", h,             12'hF88);
    chk("rst_voffset", v,             12'h0DC);
    chk("rst_active2", {11'b0, act2}, 12'h000);
    chk("rst_voffset2", v2,           12'h190);
    m_act = 0; m_k = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      txn++;
      $display("txn %0d rst_n=%b en=%b active=%b h=%h v=%h h2=%h v2=%h",
               txn, rst_n, en, act, h, v, h2, v2);
      chk("active",   {11'b0, act},  {11'b0, cur.act});
      chk("hoffset",  h,             cur.h);
      chk("voffset",  v,             cur.v);
      chk("active2",  {11'b0, act2}, {11'b0, cur.act});
      chk("hoffset2", h2,            cur.h2);
      chk("voffset2", v2,            cur.v2);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    repeat (5) tick(1'b0);

    // First sweep, with en pulses at k=5 and on the edge that clears active.
    tick(1'b1);
    chk("start_active",  {11'b0, act}, 12'h001);
    chk("start_hoffset", h,            12'hFB0);
    chk("start_voffset", v,            12'hF74);
    for (int i = 1; i <= 33; i++) begin
      tick(i == 6 || i == 33);
      if (i == 1) begin
        chk("k1_hoffset",  h,  12'hFAE);
        chk("k1_voffset",  v,  12'hF7F);
        chk("k1_hoffset2", h2, 12'h000);
        chk("k1_voffset2", v2, 12'hEE9);
      end
      if (i == 16) begin
        chk("k16_hoffset", h, 12'hF9C);
        chk("k16_voffset", v, 12'h028);
      end
      if (i == 31) begin
        chk("k31_hoffset", h, 12'hF89);
        chk("k31_voffset", v, 12'h0D0);
      end
      if (i == 32) begin
        chk("k32_active",   {11'b0, act}, 12'h001);
        chk("k32_hoffset",  h,            12'hF88);
        chk("k32_voffset",  v,            12'h0DC);
        chk("k32_voffset2", v2,           12'h190);
      end
      if (i == 33) begin
        chk("k33_active",  {11'b0, act}, 12'h000);
        chk("k33_hoffset", h,            12'hF88);
        chk("k33_voffset", v,            12'h0DC);
      end
    end
    tick(1'b1);
    chk("restart_active",  {11'b0, act}, 12'h001);
    chk("restart_hoffset", h,            12'hFB0);
    chk("restart_voffset", v,            12'hF74);

    // Continuous request: sweeps repeat every STEP+2 ticks.
    repeat (100) tick(1'b1);
    repeat (40) tick(1'b0);

    // Reset in the middle of a sweep.
    tick(1'b1);
    repeat (10) tick(1'b0);
    chk("mid_k10_hoffset", h, lerp(-80, -120, 10));
    do_reset();
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    repeat (5) tick(1'b0);
    chk("post_reset_idle", {11'b0, act}, 12'h000);

    // Random requests with occasional asynchronous resets.
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        tick(1'($urandom_range(0, 1)));
        rst_n = 1'b1;
      end else begin
        tick($urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_spawn.md
Name: sprite_spawn

Overview:
- Per-sprite motion generator for the game renderer.
- On a trigger, it sweeps a sprite's horizontal and vertical screen offsets linearly from a source point to a destination point over a fixed number of clock ticks. The top level clocks it once per frame (vsync).
- It raises `active` while the sweep runs; the top level uses `active` to stop other spawners from starting at the same time.
- `hoffset`/`voffset` feed a layer renderer's position inputs.

Parameters:
- HWIDTH, 12, width of hoffset (two's complement).
- VWIDTH, 12, width of voffset (two's complement).
- HSRC, 0, horizontal start offset (signed, HWIDTH bits).
- VSRC, 0, vertical start offset (signed, VWIDTH bits).
- HDST, 0, horizontal end offset (signed).
- VDST, 0, vertical end offset (signed).
- STEP, 32, ticks per sweep; must be a power of two, >= 2. Elaboration fails otherwise.

Ports:
- clk  input  1  sweep tick, rising edge (frame strobe at top level).
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  start request, sampled on the rising clk edge.
- hoffset  output  HWIDTH  current horizontal offset, registered.
- voffset  output  VWIDTH  current vertical offset, registered.
- active  output  1  high while a sweep is in progress, registered.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Internal state:
  - idle/running flag (drives `active`);
  - step counter k, width log2(STEP)+1, range 0..STEP.
- Reset (rst_n low, any time, including mid-sweep):
  - active=0, k=0, hoffset=HDST, voffset=VDST.
  - Effective immediately, with no clock edge needed.
  - Any sweep in progress is abandoned.
- Idle (active=0):
  - Offsets hold at HDST/VDST. Designers choose DST values so a parked sprite sits off-screen or behind scenery.
  - A rising edge with en=1 starts a sweep: next state active=1, k=0, hoffset=HSRC, voffset=VSRC. Latency 1 edge.
  - A rising edge with en=0 changes nothing.
- Running (active=1):
  - Each rising edge: k <= k+1, and the offsets are updated for the new k.
  - hoffset(k) = HSRC + (((HDST-HSRC) * k) >>> log2(STEP)).
  - voffset(k) = VSRC + (((VDST-VSRC) * k) >>> log2(STEP)).
  - The difference and product are computed signed, in WIDTH+log2(STEP)+2 bits, so there is no intermediate overflow.
  - The shift is arithmetic, so results round toward negative infinity.
  - The result is truncated to the output width (mod 2^WIDTH).
  - At k=STEP the outputs equal HDST/VDST exactly, and active stays 1 for that tick.
  - On the next edge: active=0, k=0, offsets stay at DST.
- Timing:
  - active is high for exactly STEP+1 consecutive edges-intervals per sweep.
  - `en` is ignored while active=1. A request on the edge that clears active is also ignored.
  - Earliest restart is one idle edge later, so back-to-back sweeps have one idle tick between them.
- en held high continuously: sweeps repeat with period STEP+2 ticks.
- Output stability: all outputs change only on rising clk or on asynchronous reset assertion, and they are glitch-free.
- Direction handling: SRC>DST on either axis is legal, and the negative delta uses the same formula.
- DST==SRC on an axis: that offset is constant for the whole sweep.

Test Plan:
- Setup for all scenarios: HWIDTH=VWIDTH=12, HSRC=-80, VSRC=-140, HDST=-120, VDST=220, STEP=32.
- Reset: assert rst_n=0 between clocks.
  - Required: hoffset=12'hF88 (-120), voffset=12'h0DC (220), active=0 immediately.
  - Release rst_n with en=0 for 5 ticks: outputs unchanged.
- Start: en=1 for one edge, then en=0.
  - Next edge: active=1, hoffset=12'hFB0 (-80), voffset=12'hF74 (-140).
  - k=1: hoffset=-82, voffset=-129.
  - k=16: hoffset=-100, voffset=40.
  - k=31: hoffset=-119, voffset=208.
  - k=32: hoffset=-120, voffset=220, active=1.
  - k=33: active=0, offsets hold at -120/220.
- Ignore while busy: pulse en at k=5 and at k=32.
  - Required: the sweep continues unchanged, and active falls after k=32.
  - Then en=1 on the next idle edge: restart at -80/-140.
- Continuous en=1 for 100 ticks.
  - Required: active pattern is 33 high, 1 low, repeating; each sweep starts at SRC.
- Reset mid-sweep: drop rst_n at k=10.
  - Required: asynchronously active=0 and offsets -120/220.
  - After release, no sweep until en is asserted again.
- Same-axis check: HSRC=HDST=0, VSRC=-300, VDST=400.
  - Required: hoffset stays 0 throughout.
  - voffset at k=1 is -279 (700>>>5=21); at k=32 it is 400.
